// File: rtl/slime_contact_pkg.sv
// Shared game constants for slime contact handling: hitbox sizes, timing and FSM encoding.
package slime_contact_pkg;

    localparam int unsigned DefJackW       = 32;
    localparam int unsigned DefJackH       = 48;
    localparam int unsigned DefSlimeW      = 32;
    localparam int unsigned DefSlimeH      = 24;
    localparam int unsigned DefStompMargin = 8;
    localparam int unsigned DefDyingTicks  = 16;

    localparam logic [31:0] FrameTick = 32'd6000000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAlive = 2'd1,
        StDying = 2'd2,
        StDead  = 2'd3
    } slime_state_e;

endpackage

// File: rtl/slime_contact_if.sv
// Bundle of game-state inputs and per-slime contact outputs for slime_contact.
interface slime_contact_if;

    logic [31:0] ipcnt;
    logic [10:0] jack_x;
    logic [9:0]  jack_y;
    logic        jack_falling;
    logic [10:0] slime0_x;
    logic [10:0] slime1_x;
    logic [9:0]  slime0_y;
    logic [9:0]  slime1_y;
    logic [1:0]  slime_en;
    logic [1:0]  slim_damage;
    logic [1:0]  slime_alive;
    logic [1:0]  stomp_pulse;

    modport master (
        output ipcnt, jack_x, jack_y, jack_falling,
        output slime0_x, slime1_x, slime0_y, slime1_y, slime_en,
        input  slim_damage, slime_alive, stomp_pulse
    );

    modport slave (
        input  ipcnt, jack_x, jack_y, jack_falling,
        input  slime0_x, slime1_x, slime0_y, slime1_y, slime_en,
        output slim_damage, slime_alive, stomp_pulse
    );

endinterface

// File: rtl/slime_fsm.sv
// Per-slime lifecycle FSM with DYING tick counter and registered contact outputs.
module slime_fsm
    import slime_contact_pkg::*;
#(
    parameter int unsigned DYING_TICKS = DefDyingTicks
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic en,
    input  logic overlap,
    input  logic stomp,
    output logic damage,
    output logic alive,
    output logic pulse
);

    localparam int unsigned CntW =
        ($clog2(DYING_TICKS + 1) > 5) ? $clog2(DYING_TICKS + 1) : 5;
    localparam logic [CntW-1:0] LastCnt = CntW'(DYING_TICKS - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    slime_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            damage_q, damage_d;
    logic            alive_q, alive_d;
    logic            pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            damage_q <= 1'b0;
            alive_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            damage_q <= damage_d;
            alive_q  <= alive_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        damage_d = damage_q;
        pulse_d  = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (en) state_d = StAlive;
                end
                StAlive: begin
                    if (stomp) begin
                        state_d = StDying;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else if (!en) begin
                        state_d = StIdle;
                    end
                end
                StDying: begin
                    // Entry tick is count zero; the DYING_TICKS-th tick after it leaves.
                    if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= LastCnt) state_d = StDead;
                end
                StDead: begin
                    if (!en) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            damage_d = (state_d == StAlive) && overlap && !stomp;
        end
        alive_d = (state_d == StAlive) || (state_d == StDying);
    end

    assign damage = damage_q;
    assign alive  = alive_q;
    assign pulse  = pulse_q;

endmodule

// File: rtl/slime_contact.sv
// Jack-vs-slime hitbox comparators and two independent slime lifecycle FSMs.
module slime_contact
    import slime_contact_pkg::*;
#(
    parameter int unsigned JACK_W       = DefJackW,
    parameter int unsigned JACK_H       = DefJackH,
    parameter int unsigned SLIME_W      = DefSlimeW,
    parameter int unsigned SLIME_H      = DefSlimeH,
    parameter int unsigned STOMP_MARGIN = DefStompMargin,
    parameter int unsigned DYING_TICKS  = DefDyingTicks
) (
    input logic            clk,
    input logic            reset,
    slime_contact_if.slave bus
);

    localparam logic [11:0] JackW  = 12'(JACK_W);
    localparam logic [11:0] JackH  = 12'(JACK_H);
    localparam logic [11:0] SlimeW = 12'(SLIME_W);
    localparam logic [11:0] SlimeH = 12'(SLIME_H);
    localparam logic [11:0] Margin = 12'(STOMP_MARGIN);

    logic        tick;
    logic [11:0] jx, jy, jx_end, jy_end;
    logic [11:0] sx [2];
    logic [11:0] sy [2];
    logic [1:0]  damage, alive, pulse;

    assign tick = (bus.ipcnt == FrameTick);

    // 12-bit arithmetic keeps every edge sum below 4096, so nothing wraps.
    assign jx     = {1'b0, bus.jack_x};
    assign jy     = {2'b0, bus.jack_y};
    assign jx_end = jx + JackW;
    assign jy_end = jy + JackH;
    assign sx[0]  = {1'b0, bus.slime0_x};
    assign sx[1]  = {1'b0, bus.slime1_x};
    assign sy[0]  = {2'b0, bus.slime0_y};
    assign sy[1]  = {2'b0, bus.slime1_y};

    for (genvar i = 0; i < 2; i++) begin : g_slime
        logic overlap, stomp;

        assign overlap = (jx < sx[i] + SlimeW) && (sx[i] < jx_end) &&
                         (jy < sy[i] + SlimeH) && (sy[i] < jy_end);
        assign stomp   = overlap && bus.jack_falling && (jy_end <= sy[i] + Margin);

        slime_fsm #(
            .DYING_TICKS(DYING_TICKS)
        ) u_fsm (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .en     (bus.slime_en[i]),
            .overlap(overlap),
            .stomp  (stomp),
            .damage (damage[i]),
            .alive  (alive[i]),
            .pulse  (pulse[i])
        );
    end

    assign bus.slim_damage = damage;
    assign bus.slime_alive = alive;
    assign bus.stomp_pulse = pulse;

endmodule

// File: doc/slime_contact.md
SLIME_CONTACT -- requirements
Module: slime_contact

Interface
REQ-001 JACK_W, 32, Jack hitbox width in pixels.
REQ-002 JACK_H, 48, Jack hitbox height in pixels.
REQ-003 SLIME_W, 32, slime hitbox width in pixels.
REQ-004 SLIME_H, 24, slime hitbox height in pixels.
REQ-005 STOMP_MARGIN, 8, maximum depth in pixels by which Jack's feet may sink below a slime's top edge and still count as a stomp.
REQ-006 DYING_TICKS, 16, number of frame ticks a stomped slime stays in DYING.
REQ-007 clk  in  1  system clock; one clock domain only.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 ipcnt  in  32  free-running cycle counter; the cycle with ipcnt==6000000 is the frame tick.
REQ-010 jack_x / jack_y  in  11 / 10  Jack hitbox top-left corner.
REQ-011 jack_falling  in  1  high while Jack's vertical velocity points downward.
REQ-012 slime0_x, slime1_x / slime0_y, slime1_y  in  11 / 10  slime hitbox top-left corners.
REQ-013 slime_en  in  2  per-slime spawn enable from the level logic.
REQ-014 slim_damage  out  2  per-slime contact-damage level, consumed by the health counter.
REQ-015 slime_alive  out  2  per-slime "draw and collide" flag for the renderer.
REQ-016 stomp_pulse  out  2  one-clock pulse per slime kill, for the score logic.

Function
REQ-017 All inputs SHALL be sampled only on the frame-tick cycle; outputs SHALL update on the clock edge after that cycle, giving 1-cycle latency.
REQ-018 Overlap for slime i SHALL be: jack_x < sx+SLIME_W, sx < jack_x+JACK_W, jack_y < sy+SLIME_H, and sy < jack_y+JACK_H, all strict and computed 12 bits wide so that no sum wraps.
REQ-019 Stomp for slime i SHALL be: overlap, jack_falling==1, and jack_y+JACK_H <= sy+STOMP_MARGIN.
REQ-020 Each slime SHALL have one FSM with states IDLE, ALIVE, DYING, and DEAD.
REQ-021 IDLE -> ALIVE on a tick with slime_en[i]==1.
REQ-022 ALIVE -> DYING on a tick with stomp.
REQ-023 ALIVE -> IDLE on a tick with slime_en[i]==0.
REQ-024 DYING -> DEAD after DYING_TICKS ticks, counted from the tick on which DYING is entered.
REQ-025 DEAD -> IDLE on a tick with slime_en[i]==0; DEAD never re-arms while the enable is held.
REQ-026 slim_damage[i] SHALL be 1 exactly when the FSM is ALIVE and the last tick saw overlap without stomp; it SHALL be held stable until the next tick.
REQ-027 Stomp SHALL take precedence over damage for the same slime on the same tick.
REQ-028 The two slimes SHALL be evaluated independently, so a stomp on one slime and damage from the other on the same tick produce both outputs.
REQ-029 slime_alive[i] SHALL be 1 in ALIVE and DYING, and 0 otherwise.
REQ-030 stomp_pulse[i] SHALL be high for exactly the one clock on which the FSM enters DYING.
REQ-031 The DYING counter SHALL be at least 5 bits wide, SHALL saturate, and SHALL never wrap.
REQ-032 Non-tick cycles SHALL change no state except clearing stomp_pulse.

Reset
REQ-033 On reset==0 at a clock edge, both FSMs SHALL go to IDLE, counters SHALL go to 0, and slim_damage, slime_alive, and stomp_pulse SHALL go to 2'b00, including when reset is asserted mid-DYING.
REQ-034 A frame tick coinciding with reset==0 SHALL be ignored.

Structure
REQ-035 The hitbox and timing parameter defaults and the FSM state encoding SHALL live in the shared game constants package.
REQ-036 One sub-module, slime_fsm, SHALL hold the per-slime FSM, DYING counter, and output registers, and SHALL be instantiated twice.
REQ-037 The overlap and stomp comparators SHALL be combinational in the top level.

Verification
REQ-038 slime_en=01, jack=(100,200), slime0=(120,220), jack_falling=0, tick -> next cycle slim_damage=01 and slime_alive=01.
REQ-039 Same positions but jack_y=180, so feet are at 228 <= 220+8, with jack_falling=1, tick -> stomp_pulse=01 for 1 cycle, slim_damage=00, slime_alive stays 01 for 16 ticks then becomes 00.
REQ-040 jack_x=152, slime0_x=120, so the edges touch, any y -> no overlap and slim_damage=00, covering the strict boundary.
REQ-041 Stomp slime0 and overlap slime1 without stomp on the same tick -> stomp_pulse=01 and slim_damage=10.
REQ-042 reset=0 pulsed during slime0 DYING at tick 5 -> all outputs 00; after release, slime_en=01 and a tick -> ALIVE again.
REQ-043 Overlap held with no frame tick for 1000 cycles -> outputs unchanged; slime_x=2047, jack_x=2040 -> overlap detected without wrap.
